// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants and colour type for the display blocks.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

  typedef logic [23:0] rgb_t;

  // Pick the foreground colour for a set image bit, background otherwise.
  function automatic rgb_t pick_color(input logic bit_on, input rgb_t fg, input rgb_t bg);
    return bit_on ? fg : bg;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters with stage-0 decode of active video, sync windows and frame end.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int HC_W     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VC_W     = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic [HC_W-1:0] o_hc,
  output logic [VC_W-1:0] o_vc,
  output logic            o_active,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic            o_last
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT    = HC_W'(H_ACTIVE);
  localparam logic [VC_W-1:0] V_ACT    = VC_W'(V_ACTIVE);
  localparam logic [HC_W-1:0] HS_START = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] VS_START = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [HC_W-1:0] r_hc;
  logic [VC_W-1:0] r_vc;

  // Stage 0: pixel counter wraps each line, line counter advances on that wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (r_hc == H_LAST) begin
      r_hc <= '0;
      r_vc <= (r_vc == V_LAST) ? '0 : r_vc + VC_W'(1);
    end else begin
      r_hc <= r_hc + HC_W'(1);
    end
  end

  // Decode the current counter position into raster flags.
  always_comb begin
    o_hc     = r_hc;
    o_vc     = r_vc;
    o_active = (r_hc < H_ACT) && (r_vc < V_ACT);
    o_hsync  = (r_hc >= HS_START) && (r_hc < HS_END);
    o_vsync  = (r_vc >= VS_START) && (r_vc < VS_END);
    o_last   = (r_hc == H_LAST) && (r_vc == V_LAST);
  end

endmodule

// File: rtl/vga_image_scanner.sv
// Raster scanner: walks a 1-bpp image ROM and drives the VGA DAC with a 2-clk pipeline.
module vga_image_scanner
  import vga_pkg::*;
#(
  parameter int   ADDR_WIDTH = 19,
  parameter int   H_ACTIVE   = VGA_H_ACTIVE,
  parameter int   H_FP       = VGA_H_FP,
  parameter int   H_SYNC     = VGA_H_SYNC,
  parameter int   H_BP       = VGA_H_BP,
  parameter int   V_ACTIVE   = VGA_V_ACTIVE,
  parameter int   V_FP       = VGA_V_FP,
  parameter int   V_SYNC     = VGA_V_SYNC,
  parameter int   V_BP       = VGA_V_BP,
  parameter rgb_t FG_RESET   = 24'hFFFFFF,
  parameter rgb_t BG_RESET   = 24'h000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  rgb_t                  fg_color,
  input  rgb_t                  bg_color,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic                  rom_q,
  output logic [7:0]            vga_r,
  output logic [7:0]            vga_g,
  output logic [7:0]            vga_b,
  output logic                  vga_hs_n,
  output logic                  vga_vs_n,
  output logic                  vga_blank_n,
  output logic                  vga_sync_n,
  output logic                  frame_start
);

  localparam int HC_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VC_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  logic [HC_W-1:0] w_hc;
  logic [VC_W-1:0] w_vc;
  logic            w_active;
  logic            w_hsync;
  logic            w_vsync;
  logic            w_last;
  logic            w_first;
  rgb_t            w_pix_rgb;

  logic [ADDR_WIDTH-1:0] r_rom_addr;
  rgb_t                  r_fg_s;
  rgb_t                  r_bg_s;

  logic r_vld_p1;
  logic r_hs_p1;
  logic r_vs_p1;
  logic r_fs_p1;

  rgb_t r_rgb_p2;
  logic r_hs_n_p2;
  logic r_vs_n_p2;
  logic r_blank_n_p2;
  logic r_fs_p2;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HC_W     (HC_W),
    .VC_W     (VC_W)
  ) u_timing (
    .i_clk    (clk),
    .i_reset  (reset),
    .o_hc     (w_hc),
    .o_vc     (w_vc),
    .o_active (w_active),
    .o_hsync  (w_hsync),
    .o_vsync  (w_vsync),
    .o_last   (w_last)
  );

  assign w_first = (w_hc == '0) && (w_vc == '0);

  // Stage 0: incremental ROM address; counts active pixels, rewinds at frame end.
  always_ff @(posedge clk) begin
    if (reset || w_last) begin
      r_rom_addr <= '0;
    end else if (w_active) begin
      r_rom_addr <= r_rom_addr + ADDR_WIDTH'(1);
    end
  end

  // Colour shadows only update at the frame boundary so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fg_s <= FG_RESET;
      r_bg_s <= BG_RESET;
    end else if (w_last) begin
      r_fg_s <= fg_color;
      r_bg_s <= bg_color;
    end
  end

  // Stage 1: flags wait one clk while the ROM returns the pixel bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_hs_p1  <= 1'b0;
      r_vs_p1  <= 1'b0;
      r_fs_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= w_active;
      r_hs_p1  <= w_hsync;
      r_vs_p1  <= w_vsync;
      r_fs_p1  <= w_first;
    end
  end

  assign w_pix_rgb = r_vld_p1 ? pick_color(rom_q, r_fg_s, r_bg_s) : '0;

  // Stage 2: registered VGA pins, colour forced black outside active video.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb_p2     <= '0;
      r_hs_n_p2    <= 1'b1;
      r_vs_n_p2    <= 1'b1;
      r_blank_n_p2 <= 1'b0;
      r_fs_p2      <= 1'b0;
    end else begin
      r_rgb_p2     <= w_pix_rgb;
      r_hs_n_p2    <= ~r_hs_p1;
      r_vs_n_p2    <= ~r_vs_p1;
      r_blank_n_p2 <= r_vld_p1;
      r_fs_p2      <= r_fs_p1;
    end
  end

  assign rom_addr    = r_rom_addr;
  assign vga_r       = r_rgb_p2[23:16];
  assign vga_g       = r_rgb_p2[15:8];
  assign vga_b       = r_rgb_p2[7:0];
  assign vga_hs_n    = r_hs_n_p2;
  assign vga_vs_n    = r_vs_n_p2;
  assign vga_blank_n = r_blank_n_p2;
  assign vga_sync_n  = 1'b0;
  assign frame_start = r_fs_p2;

endmodule

// File: tb/tb_vga_image_scanner.sv
// Bench for vga_image_scanner on a scaled-down raster (15x10 total, 8x6 active).
module tb_vga_image_scanner;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2, HT = HA + HFP + HS + HBP;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1, VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int AW = 19;
  localparam int NV = 19;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [23:0]   fg_color;
  logic [23:0]   bg_color;
  logic [AW-1:0] rom_addr;
  logic          rom_q = 1'b0;
  logic [7:0]    vga_r, vga_g, vga_b;
  logic          vga_hs_n, vga_vs_n, vga_blank_n, vga_sync_n, frame_start;

  logic all_ones = 1'b0;

  always #5 clk = ~clk;

  vga_image_scanner #(
    .ADDR_WIDTH (AW),
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .FG_RESET (24'hFFFFFF), .BG_RESET (24'h000000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fg_color    (fg_color),
    .bg_color    (bg_color),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs_n    (vga_hs_n),
    .vga_vs_n    (vga_vs_n),
    .vga_blank_n (vga_blank_n),
    .vga_sync_n  (vga_sync_n),
    .frame_start (frame_start)
  );

  function automatic logic rom_bit(input logic [AW-1:0] a, input logic ones);
    return ones | (a[0] ^ a[2]);
  endfunction

  // Behavioural image ROM with one clk of read latency.
  always @(posedge clk) rom_q <= rom_bit(rom_addr, all_ones);

  typedef struct {
    int          k;
    logic        blank_n;
    logic        hs_n;
    logic        vs_n;
    logic        fs;
    logic [23:0] rgb;
    int          addr;
  } vec_t;

  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;
  int k;
  int epoch;
  int vi;
  int hs_run, bcnt, fcnt;
  logic prev_hs;

  function automatic vec_t mk(input int kk, input logic b, input logic h, input logic v,
                              input logic f, input logic [23:0] c, input int a);
    vec_t r;
    r.k = kk; r.blank_n = b; r.hs_n = h; r.vs_n = v; r.fs = f; r.rgb = c; r.addr = a;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d epoch=%0d: got %0h, expected %0h", name, k, epoch, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input int kk);
    int c, x, y;
    c = kk % FT; x = c % HT; y = c / HT;
    if (y < VA) return AW'(y * HA + ((x < HA) ? x : HA));
    return AW'(HA * VA);
  endfunction

  function automatic logic [23:0] exp_fg(input int ep, input int f);
    if (f == 0) return 24'hFFFFFF;
    if (ep == 0 && f == 1) return 24'hFFFFFF;
    return 24'h00FF00;
  endfunction

  function automatic logic [23:0] exp_bg(input int f);
    return (f == 0) ? 24'h000000 : 24'h202020;
  endfunction

  function automatic logic exp_ones(input int ep, input int f);
    return (ep == 0) && (f >= 3);
  endfunction

  task automatic check_cycle();
    int j, f, c, x, y, pa;
    logic act, ehs, evs, efs;
    logic [23:0] ergb;
    logic [23:0] rgb;
    rgb = {vga_r, vga_g, vga_b};
    cmp("rom_addr", rom_addr, exp_addr(k));
    if (k < 2) begin
      cmp("pre_rgb", rgb, 24'h0);
      cmp("pre_blank_n", vga_blank_n, 1'b0);
      cmp("pre_hs_n", vga_hs_n, 1'b1);
      cmp("pre_vs_n", vga_vs_n, 1'b1);
      cmp("pre_frame_start", frame_start, 1'b0);
    end else begin
      j = k - 2; f = j / FT; c = j % FT; x = c % HT; y = c / HT;
      act = (x < HA) && (y < VA);
      ehs = !((x >= HA + HFP) && (x < HA + HFP + HS));
      evs = !((y >= VA + VFP) && (y < VA + VFP + VS));
      efs = (c == 0);
      pa = y * HA + x;
      ergb = act ? (rom_bit(AW'(pa), exp_ones(epoch, f)) ? exp_fg(epoch, f) : exp_bg(f)) : 24'h0;
      cmp("rgb", rgb, ergb);
      cmp("blank_n", vga_blank_n, act);
      cmp("hs_n", vga_hs_n, ehs);
      cmp("vs_n", vga_vs_n, evs);
      cmp("frame_start", frame_start, efs);
      if (vga_blank_n) bcnt++;
      if (frame_start) fcnt++;
      if (c == FT - 1) begin
        cmp("blank_per_frame", bcnt, HA * VA);
        cmp("fs_per_frame", fcnt, 1);
        bcnt = 0; fcnt = 0;
      end
    end
    if (vga_blank_n === 1'b0) cmp("blank_black", rgb, 24'h0);
    if (vga_hs_n === 1'b0) hs_run++;
    else if (prev_hs === 1'b0) begin
      cmp("hs_width", hs_run, HS);
      hs_run = 0;
    end
    prev_hs = vga_hs_n;
    if (epoch == 0 && vi < NV && vecs[vi].k == k) begin
      cmp("vec_blank_n", vga_blank_n, vecs[vi].blank_n);
      cmp("vec_hs_n", vga_hs_n, vecs[vi].hs_n);
      cmp("vec_vs_n", vga_vs_n, vecs[vi].vs_n);
      cmp("vec_fs", frame_start, vecs[vi].fs);
      cmp("vec_rgb", rgb, vecs[vi].rgb);
      cmp("vec_addr", rom_addr, vecs[vi].addr);
      vi++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  initial begin
    //             k    blank hs  vs  fs  rgb           addr
    vecs[0]  = mk(0,   0, 1, 1, 0, 24'h000000, 0);
    vecs[1]  = mk(1,   0, 1, 1, 0, 24'h000000, 1);
    vecs[2]  = mk(2,   1, 1, 1, 1, 24'h000000, 2);
    vecs[3]  = mk(3,   1, 1, 1, 0, 24'hFFFFFF, 3);
    vecs[4]  = mk(6,   1, 1, 1, 0, 24'hFFFFFF, 6);
    vecs[5]  = mk(7,   1, 1, 1, 0, 24'h000000, 7);
    vecs[6]  = mk(10,  0, 1, 1, 0, 24'h000000, 8);
    vecs[7]  = mk(12,  0, 0, 1, 0, 24'h000000, 8);
    vecs[8]  = mk(14,  0, 0, 1, 0, 24'h000000, 8);
    vecs[9]  = mk(15,  0, 1, 1, 0, 24'h000000, 8);
    vecs[10] = mk(17,  1, 1, 1, 0, 24'h000000, 10);
    vecs[11] = mk(18,  1, 1, 1, 0, 24'hFFFFFF, 11);
    vecs[12] = mk(106, 0, 1, 1, 0, 24'h000000, 48);
    vecs[13] = mk(107, 0, 1, 0, 0, 24'h000000, 48);
    vecs[14] = mk(136, 0, 1, 0, 0, 24'h000000, 48);
    vecs[15] = mk(149, 0, 0, 1, 0, 24'h000000, 48);
    vecs[16] = mk(150, 0, 1, 1, 0, 24'h000000, 0);
    vecs[17] = mk(152, 1, 1, 1, 1, 24'h202020, 2);
    vecs[18] = mk(153, 1, 1, 1, 0, 24'hFFFFFF, 3);

    fg_color = 24'hFFFFFF;
    bg_color = 24'h202020;
    epoch = 0; vi = 0; hs_run = 0; bcnt = 0; fcnt = 0; prev_hs = 1'b1;
    k = -3;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      cmp("rst_blank_n", vga_blank_n, 1'b0);
      cmp("rst_hs_n", vga_hs_n, 1'b1);
      cmp("rst_addr", rom_addr, 0);
      k++;
    end
    reset = 1'b0;
    k = 0;
    check_cycle();

    // Four frames: colour change mid-frame 1, all-ones ROM from frame 3.
    while (k < 650) begin
      if (k == 195) fg_color = 24'h00FF00;
      if (k == 420) all_ones = 1'b1;
      step();
      check_cycle();
    end

    // Single-clk reset at counter (5,3) of frame 4.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    all_ones = 1'b0;
    epoch = 1; k = 0; hs_run = 0; bcnt = 0; fcnt = 0; prev_hs = 1'b1;
    check_cycle();
    while (k < 320) begin
      step();
      check_cycle();
    end

    cmp("vectors_applied", vi, NV);
    cmp("sync_n", vga_sync_n, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_image_scanner.md
# vga_image_scanner

Raster scanner that drives the DE2-115 VGA DAC from the 1-bit-per-pixel image ROM. It generates 640x480@60 Hz timing from a 25 MHz pixel clock, issues one ROM address per active pixel, absorbs the ROM's one-cycle read latency, and maps each bit to a 24-bit foreground or background colour. The ROM sits directly downstream on `rom_addr` and feeds back on `rom_q`; the VGA pins sit downstream of this block.

## Interface
- `ADDR_WIDTH`, 19: ROM address width; must satisfy 2^ADDR_WIDTH ≥ H_ACTIVE*V_ACTIVE.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal timing in pixels.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing in lines.
- `FG_RESET`, 24'hFFFFFF: foreground colour after reset.
- `BG_RESET`, 24'h000000: background colour after reset.

Ports:
- `clk` in 1: 25 MHz pixel clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `fg_color` in 24: {R,G,B} colour for ROM bit 1.
- `bg_color` in 24: {R,G,B} colour for ROM bit 0.
- `rom_addr` out ADDR_WIDTH: registered ROM address.
- `rom_q` in 1: ROM data, valid one clk after `rom_addr`.
- `vga_r`/`vga_g`/`vga_b` out 8 each: registered colour.
- `vga_hs_n` out 1: horizontal sync, active-low.
- `vga_vs_n` out 1: vertical sync, active-low.
- `vga_blank_n` out 1: high during active video.
- `vga_sync_n` out 1: constant 0 (composite sync unused).
- `frame_start` out 1: one-cycle pulse aligned with the output of pixel (0,0).

## Operation
- Counters `hc` 0..H_TOTAL-1 (800) and `vc` 0..V_TOTAL-1 (525). `hc` wraps every cycle count; `vc` increments when `hc` wraps and itself wraps at 524.
- Active: `hc < 640 && vc < 480`. Hsync low for `hc` in 656..751. Vsync low for `vc` in 490..491.
- Address is generated incrementally, with no multiplier:
  - `rom_addr` increments by 1 on every active cycle.
  - It holds during blanking.
  - It loads 0 on the last cycle of the frame (`hc=799, vc=524`).
  - Invariant: while counters show active (x,y), `rom_addr = y*640+x`. The maximum value reached is 307200, held during vertical blanking.
- Colour shadow registers `fg_s`/`bg_s` load `fg_color`/`bg_color` only on the last cycle of the frame. Changes therefore take effect from the next frame and never tear mid-frame.
- Pixel colour:
  - Active and `rom_q=1`: `fg_s`.
  - Active and `rom_q=0`: `bg_s`.
  - Not active: 24'h000000.

## Timing
- Pipeline:
  - Stage 0: counters and `rom_addr`.
  - Stage 1: ROM register; active/hs/vs/frame-start flags delayed one cycle.
  - Stage 2: output registers.
- All VGA outputs lag the counters by exactly 2 clk. Sync, blank and colour are mutually aligned.
- Reset values:
  - `hc=vc=0`, `rom_addr=0`, `fg_s=FG_RESET`, `bg_s=BG_RESET`.
  - All delay flags inactive.
  - `vga_r/g/b=0`, `vga_hs_n=1`, `vga_vs_n=1`, `vga_blank_n=0`, `frame_start=0`.
- First cycle after `reset` falls: counters show (0,0) and `rom_addr=0`. The pixel (0,0) colour, `vga_blank_n=1` and `frame_start=1` appear 2 clk later.
- Reset asserted mid-frame: every register returns to its reset value on that edge. The raster restarts cleanly at (0,0) and no partial pulse is extended.
- Frame period: 420000 clk. Line period: 800 clk.

## Structure
- Shared package `vga_pkg`:
  - 640x480 timing constants.
  - Derived `H_TOTAL`/`V_TOTAL`.
  - Sync start/end constants.
  - 24-bit colour type.
- Sub-module `vga_timing`: `hc`/`vc` counters plus stage-0 active/hs/vs/last-of-frame decode, reusable by other display blocks.
- `vga_image_scanner` adds the address counter, colour shadows and stages 1–2.

## Test plan
- **Reset release:** hold `reset` 3 clk, then release. Outputs hold reset values until 2 clk after release. `frame_start=1` and `vga_blank_n=1` exactly once per 420000 clk thereafter.
- **Sync timing:** count over one frame. `vga_hs_n` low 96 clk starting 656 clk after the line's first active pixel output. `vga_vs_n` low for 1600 clk starting 490 lines after `frame_start`. `vga_blank_n` high for exactly 307200 clk per frame.
- **Addressing and alignment:** behavioural ROM model with bit = `addr[0]^addr[9]`. Output colour at screen (x,y) matches ROM[y*640+x] for all active pixels. `rom_addr=307200` during vertical blank; `rom_addr=0` at the (0,0) counter cycle.
- **Colour latch:** change `fg_color` to 24'h00FF00 at mid-frame (vc=200). The current frame stays FFFFFF on bit-1 pixels; the next frame starts 00FF00 from pixel (0,0).
- **Blanking:** all-ones ROM. `vga_r/g/b=0` whenever `vga_blank_n=0`, including the first and last clk of each blanking interval.
- **Reset mid-frame:** assert `reset` 1 clk at (hc=300, vc=100). Next cycle counters show (0,0) and `rom_addr=0`. `frame_start` pulses 2 clk after release; no hsync pulse is truncated into a runt shorter than 96 clk after restart.
